instr_mem_loader: RTL and testbench

Boot-load controller for the word-addressed instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into the memory's write port and validates a trailing additive checksum. The CPU is held in stall until a load completes cleanly; after that, CPU fetch addresses pass through to the memory read port.

---
 rtl/instr_mem_loader.sv | 140 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot-load controller: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory, verifies a trailing checksum and gates the CPU.
module instr_mem_loader #(
    parameter int DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load_start,
    input  logic [31:0] i_load_word_count,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    input  logic [31:0] i_fetch_addr,
    output logic [31:0] o_mem_raddr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_waddr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_stall,
    output logic        o_load_done,
    output logic        o_load_error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_count;
    logic [31:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_sum;
    logic [23:0] r_bytes;
    logic        r_mem_we;
    logic [31:0] r_mem_waddr;
    logic [31:0] r_mem_wdata;

    logic        w_start_window;
    logic        w_count_bad;
    logic        w_accept_start;
    logic        w_xfer;
    logic        w_fourth_byte;
    logic        w_last_word;
    logic [31:0] w_word;

    assign w_start_window = (r_state == IDLE) || (r_state == RUN) || (r_state == ERROR);
    assign w_count_bad    = (i_load_word_count == 32'd0) || (i_load_word_count > 32'(DEPTH));
    assign w_accept_start = w_start_window && i_load_start && !w_count_bad;
    assign w_xfer         = i_byte_valid && o_byte_ready;
    assign w_fourth_byte  = w_xfer && (r_byte_idx == 2'd3);
    assign w_last_word    = (r_word_idx == r_count - 32'd1);
    assign w_word         = {i_byte_data, r_bytes};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RUN, ERROR: begin
                if (i_load_start) begin
                    w_next = w_count_bad ? ERROR : LOAD;
                end
            end
            LOAD: begin
                if (w_fourth_byte && w_last_word) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_fourth_byte) begin
                    w_next = (w_word == r_sum) ? RUN : ERROR;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = (r_state == LOAD) || (r_state == CHECK);
        o_cpu_stall  = (r_state != RUN);
        o_load_done  = (r_state == RUN);
        o_load_error = (r_state == ERROR);
        o_mem_raddr  = (r_state == RUN) ? i_fetch_addr : 32'd0;
    end

    // Byte assembly shares one path for program words and the checksum word;
    // only words completed in LOAD reach the memory and the running sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 32'd0;
            r_word_idx  <= 32'd0;
            r_byte_idx  <= 2'd0;
            r_sum       <= 32'd0;
            r_bytes     <= 24'd0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept_start) begin
                r_count    <= i_load_word_count;
                r_word_idx <= 32'd0;
                r_byte_idx <= 2'd0;
                r_sum      <= 32'd0;
            end else if (w_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_bytes[7:0]   <= i_byte_data;
                    2'd1: r_bytes[15:8]  <= i_byte_data;
                    2'd2: r_bytes[23:16] <= i_byte_data;
                    default: begin
                        if (r_state == LOAD) begin
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= r_word_idx;
                            r_mem_wdata <= w_word;
                            r_sum       <= r_sum + w_word;
                            r_word_idx  <= r_word_idx + 32'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_waddr = r_mem_waddr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a per-cycle vector table for a clean load,
// followed by hand-written sequences for checksum errors, illegal counts, gaps, reset and reload.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        i_load_start;
    logic [31:0] i_load_word_count;
    logic        i_byte_valid;
    logic [7:0]  i_byte_data;
    logic        o_byte_ready;
    logic [31:0] i_fetch_addr;
    logic [31:0] o_mem_raddr;
    logic        o_mem_we;
    logic [31:0] o_mem_waddr;
    logic [31:0] o_mem_wdata;
    logic        o_cpu_stall;
    logic        o_load_done;
    logic        o_load_error;

    int checks = 0;
    int errors = 0;
    int weCount = 0;
    int weBase;
    logic [31:0] shadowMem [0:15];
    logic [31:0] progWords [0:9];

    typedef struct {
        logic        start;
        logic [31:0] count;
        logic        valid;
        logic [7:0]  data;
        logic [31:0] fetch;
        logic        expStall;
        logic        expReady;
        logic        expDone;
        logic        expErr;
        logic        expWe;
        logic [31:0] expWaddr;
        logic [31:0] expWdata;
        logic [31:0] expRaddr;
    } vec_t;

    vec_t vecs [$];

    instr_mem_loader #(.DEPTH(10)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_load_start      (i_load_start),
        .i_load_word_count (i_load_word_count),
        .i_byte_valid      (i_byte_valid),
        .i_byte_data       (i_byte_data),
        .o_byte_ready      (o_byte_ready),
        .i_fetch_addr      (i_fetch_addr),
        .o_mem_raddr       (o_mem_raddr),
        .o_mem_we          (o_mem_we),
        .o_mem_waddr       (o_mem_waddr),
        .o_mem_wdata       (o_mem_wdata),
        .o_cpu_stall       (o_cpu_stall),
        .o_load_done       (o_load_done),
        .o_load_error      (o_load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            weCount++;
            shadowMem[o_mem_waddr[3:0]] = o_mem_wdata;
        end
    end

    function automatic vec_t mkVec(logic st, logic [31:0] cnt, logic val, logic [7:0] dat,
                                   logic [31:0] fetch, logic stall, logic ready, logic done,
                                   logic err, logic we, logic [31:0] waddr, logic [31:0] wdata,
                                   logic [31:0] raddr);
        vec_t v;
        v.start = st; v.count = cnt; v.valid = val; v.data = dat; v.fetch = fetch;
        v.expStall = stall; v.expReady = ready; v.expDone = done; v.expErr = err;
        v.expWe = we; v.expWaddr = waddr; v.expWdata = wdata; v.expRaddr = raddr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_load_start      = v.start;
        i_load_word_count = v.count;
        i_byte_valid      = v.valid;
        i_byte_data       = v.data;
        i_fetch_addr      = v.fetch;
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input logic [31:0] cnt);
        i_load_start      = 1'b1;
        i_load_word_count = cnt;
        @(posedge clk);
        #1;
        i_load_start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int waited = 0;
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        while (!o_byte_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!o_byte_ready) begin
            checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        i_byte_valid = 1'b0;
        i_byte_data  = 8'($urandom);
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    i_byte_valid = 1'b0;
                    i_byte_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            sendByte(w[8*k +: 8]);
        end
    endtask

    task automatic runLoad(input int cnt, input logic [31:0] checksum, input bit gaps);
        startLoad(32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            sendWord(progWords[i], gaps);
        end
        sendWord(checksum, gaps);
    endtask

    task automatic checkStatus(input string tag, input logic stall, input logic ready,
                               input logic done, input logic err);
        checkOutput({tag, "_stall"}, 32'(o_cpu_stall), 32'(stall));
        checkOutput({tag, "_ready"}, 32'(o_byte_ready), 32'(ready));
        checkOutput({tag, "_done"}, 32'(o_load_done), 32'(done));
        checkOutput({tag, "_error"}, 32'(o_load_error), 32'(err));
    endtask

    initial begin
        rst_n             = 1'b0;
        i_load_start      = 1'b0;
        i_load_word_count = 32'd0;
        i_byte_valid      = 1'b0;
        i_byte_data       = 8'd0;
        i_fetch_addr      = 32'h0000_0042;
        for (int i = 0; i < 16; i++) shadowMem[i] = 32'hFFFF_FFFF;

        #12;
        checkStatus("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_we", 32'(o_mem_we), 32'd0);
        checkOutput("reset_waddr", o_mem_waddr, 32'd0);
        checkOutput("reset_wdata", o_mem_wdata, 32'd0);
        checkOutput("reset_raddr", o_mem_raddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean count=3 load; the first checksum byte lands while word 2's write pulse is high.
        vecs.push_back(mkVec(1, 3, 0, 8'h00, 0,      1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h01, 0,      1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h02, 0,      1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 1, 1, 2, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h03, 0,      1, 1, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 0,      1, 1, 0, 0, 1, 2, 3, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h06, 32'h77, 1, 1, 0, 0, 0, 2, 3, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 32'h77, 1, 1, 0, 0, 0, 2, 3, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 32'h77, 1, 1, 0, 0, 0, 2, 3, 0));
        vecs.push_back(mkVec(0, 0, 1, 8'h00, 32'h55, 0, 0, 1, 0, 0, 2, 3, 32'h55));
        vecs.push_back(mkVec(0, 0, 0, 8'h00, 32'h1234, 0, 0, 1, 0, 0, 2, 3, 32'h1234));
        vecs.push_back(mkVec(0, 0, 1, 8'hFF, 32'hABC, 0, 0, 1, 0, 0, 2, 3, 32'hABC));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_stall", i), 32'(o_cpu_stall), 32'(vecs[i].expStall));
            checkOutput($sformatf("v%0d_ready", i), 32'(o_byte_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("v%0d_done", i), 32'(o_load_done), 32'(vecs[i].expDone));
            checkOutput($sformatf("v%0d_error", i), 32'(o_load_error), 32'(vecs[i].expErr));
            checkOutput($sformatf("v%0d_we", i), 32'(o_mem_we), 32'(vecs[i].expWe));
            checkOutput($sformatf("v%0d_waddr", i), o_mem_waddr, vecs[i].expWaddr);
            checkOutput($sformatf("v%0d_wdata", i), o_mem_wdata, vecs[i].expWdata);
            checkOutput($sformatf("v%0d_raddr", i), o_mem_raddr, vecs[i].expRaddr);
        end
        i_byte_valid = 1'b0;
        i_fetch_addr = 32'd0;

        // Bad checksum: three writes, then ERROR with no further writes.
        progWords[0] = 32'd1; progWords[1] = 32'd2; progWords[2] = 32'd3;
        weBase = weCount;
        runLoad(3, 32'd7, 1'b0);
        checkStatus("badsum", 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("badsum_writes", 32'(weCount - weBase), 32'd3);
        i_byte_valid = 1'b1;
        repeat (4) begin
            i_byte_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        i_byte_valid = 1'b0;
        checkOutput("badsum_nowrites", 32'(weCount - weBase), 32'd3);
        checkOutput("badsum_still_error", 32'(o_load_error), 32'd1);

        // Retry from ERROR with count=1.
        progWords[0] = 32'hA5A5_0001;
        runLoad(1, 32'hA5A5_0001, 1'b0);
        checkStatus("retry", 1'b0, 1'b0, 1'b1, 1'b0);

        // Illegal count 0 from RUN.
        weBase = weCount;
        startLoad(32'd0);
        checkStatus("count0", 1'b1, 1'b0, 1'b0, 1'b1);

        // Count equal to DEPTH is legal and fills the top word.
        for (int i = 0; i < 10; i++) progWords[i] = 32'(i + 1);
        runLoad(10, 32'd55, 1'b0);
        checkStatus("depth", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("depth_writes", 32'(weCount - weBase), 32'd10);
        checkOutput("depth_word9", shadowMem[9], 32'd10);

        // Count one above DEPTH is rejected.
        weBase = weCount;
        startLoad(32'd11);
        checkStatus("count11", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("count11_nowrites", 32'(weCount - weBase), 32'd0);

        // Gappy stream with a load_start pulse mid-load that must be ignored.
        weBase = weCount;
        startLoad(32'd2);
        sendWord(32'hDEAD_BEEF, 1'b1);
        i_load_start      = 1'b1;
        i_load_word_count = 32'd0;
        @(posedge clk);
        #1;
        i_load_start = 1'b0;
        checkStatus("midstart", 1'b1, 1'b1, 1'b0, 1'b0);
        sendWord(32'h1234_5678, 1'b1);
        sendWord(32'hF0E2_1567, 1'b1);
        checkStatus("gaps", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("gaps_word0", shadowMem[0], 32'hDEAD_BEEF);
        checkOutput("gaps_word1", shadowMem[1], 32'h1234_5678);
        checkOutput("gaps_writes", 32'(weCount - weBase), 32'd2);

        // Asynchronous reset after five bytes of a count=2 load.
        startLoad(32'd2);
        sendWord(32'h1111_1111, 1'b0);
        sendByte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        checkStatus("arst", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("arst_we", 32'(o_mem_we), 32'd0);
        checkOutput("arst_waddr", o_mem_waddr, 32'd0);
        checkOutput("arst_wdata", o_mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        progWords[0] = 32'h1111_1111; progWords[1] = 32'h2222_2222;
        runLoad(2, 32'h3333_3333, 1'b0);
        checkStatus("postrst", 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("postrst_word1", shadowMem[1], 32'h2222_2222);

        // Reload from RUN holds the CPU until the new program checks out.
        startLoad(32'd1);
        checkStatus("reload_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        sendWord(32'h0BAD_F00D, 1'b0);
        checkOutput("reload_chk_stall", 32'(o_cpu_stall), 32'd1);
        checkOutput("reload_chk_done", 32'(o_load_done), 32'd0);
        sendWord(32'h0BAD_F00D, 1'b0);
        checkStatus("reload_end", 1'b0, 1'b0, 1'b1, 1'b0);
        i_fetch_addr = 32'h0000_0003;
        #1;
        checkOutput("reload_raddr", o_mem_raddr, 32'h0000_0003);
        checkOutput("reload_word0", shadowMem[0], 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
